// File: rtl/reglk_mem_ctrl.sv
// reglk_mem_ctrl
// Word memory with byte/halfword/word access, sticky per-region write locks
// and a two-key, time-limited debug-unlock window.
//
// Handshake: a request is accepted in every cycle where req=1 (there is no
// back-pressure). A read request presented at a clk edge produces rvalid=1
// with read_data during the following cycle. A write commits at the same
// edge. violation pulses for one cycle, aligned like rvalid, after a rejected
// access.
//
// Ports:
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   req             access request, one access per cycle
//   write_enable    1 = write, 0 = read (qualified by req)
//   mem_width       000 SB, 001 SH, 010 W, 100 UB, 101 UH; other codes = W
//   addr            byte address
//   write_data      right-aligned write data
//   read_data       registered read data
//   rvalid          one-cycle pulse, read_data valid
//   lock_status     sticky lock bits, one per region
//   unlocked        debug-unlock window active
//   violation       one-cycle pulse on a rejected access
//   viol_count      saturating violation counter
//   dbg_state       unlock FSM state (0 IDLE, 1 ARMED, 2 OPEN)
module reglk_mem_ctrl #(
    parameter int          DEPTH         = 256,
    parameter int          REGIONS       = 8,
    parameter logic [31:0] LOCK_ADDR     = 32'h0000_0FF0,
    parameter logic [31:0] KEY_ADDR      = 32'h0000_0FF4,
    parameter logic [31:0] KEY0          = 32'hA5A5_0001,
    parameter logic [31:0] KEY1          = 32'h5A5A_0002,
    parameter int          UNLOCK_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               write_enable,
    input  logic [2:0]         mem_width,
    input  logic [31:0]        addr,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               rvalid,
    output logic [REGIONS-1:0] lock_status,
    output logic               unlocked,
    output logic               violation,
    output logic [7:0]         viol_count,
    output logic [1:0]         dbg_state
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WPR = DEPTH / REGIONS;
    localparam int RIW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int CW  = $clog2(UNLOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_OPEN  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          fsm_viol;

    logic [31:0]   mem [DEPTH];

    // ---------------- address decode ----------------
    logic [AW-1:0]  widx;
    logic [31:0]    widx32;
    logic [31:0]    region_full;
    logic [RIW-1:0] region;
    logic           in_range, is_lock, is_key, is_read, is_write;
    logic           blocked, mem_wr, mem_viol, viol_now;

    assign widx        = addr[AW+1:2];
    assign in_range    = (addr[31:AW+2] == '0);
    assign is_lock     = (addr == LOCK_ADDR);
    assign is_key      = (addr == KEY_ADDR);
    assign is_read     = req & ~write_enable;
    assign is_write    = req & write_enable;
    // Regions are power-of-2 sized, so the region is the upper index bits.
    assign widx32      = {{(32-AW){1'b0}}, widx};
    assign region_full = widx32 >> $clog2(WPR);
    assign region      = region_full[RIW-1:0];

    assign blocked  = lock_status[region] & ~unlocked;
    assign mem_wr   = is_write & ~is_lock & ~is_key & in_range & ~blocked;
    // Reads are never lock-blocked; only range matters for them.
    assign mem_viol = req & ~is_lock & ~is_key &
                      (~in_range | (write_enable & blocked));
    assign viol_now = mem_viol | fsm_viol;

    // ---------------- write path ----------------
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = write_data;
        case (mem_width)
            3'b000, 3'b100: begin
                be        = 4'b0001 << addr[1:0];
                wdata_rep = {4{write_data[7:0]}};
            end
            3'b001, 3'b101: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    logic [31:0] word, word_sh, rd_next;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign word    = mem[widx];
    assign word_sh = word >> {addr[1:0], 3'b000};
    assign rbyte   = word_sh[7:0];
    assign rhalf   = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        rd_next = word;
        if (is_lock) begin
            rd_next = 32'(lock_status);
        end else if (is_key) begin
            rd_next = {31'b0, unlocked};
        end else if (!in_range) begin
            rd_next = 32'h0;
        end else begin
            case (mem_width)
                3'b000:  rd_next = {{24{rbyte[7]}}, rbyte};
                3'b100:  rd_next = {24'h0, rbyte};
                3'b001:  rd_next = {{16{rhalf[15]}}, rhalf};
                3'b101:  rd_next = {16'h0, rhalf};
                default: rd_next = word;
            endcase
        end
    end

    // ---------------- unlock FSM ----------------
    logic key_wr;
    assign key_wr = is_write & is_key;

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        fsm_viol   = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_wr) begin
                    if (write_data == KEY0) state_next = S_ARMED;
                    // A stray second key with no armed first key is ignored
                    // silently; any other value is a bad key.
                    else if (write_data != KEY1) fsm_viol = 1'b1;
                end
            end
            S_ARMED: begin
                // Only the next request decides; idle cycles keep ARMED.
                if (req) begin
                    state_next = S_IDLE;
                    if (key_wr) begin
                        if (write_data == KEY1) state_next = S_OPEN;
                        else                    fsm_viol   = 1'b1;
                    end
                end
            end
            S_OPEN: begin
                if (key_wr || cnt == CW'(UNLOCK_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign unlocked  = (state == S_OPEN);
    assign dbg_state = state;

    // ---------------- registered state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            read_data   <= 32'h0;
            rvalid      <= 1'b0;
            lock_status <= '0;
            violation   <= 1'b0;
            viol_count  <= 8'h0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rvalid    <= is_read;
            violation <= viol_now;
            if (is_read) read_data <= rd_next;
            if (viol_now && viol_count != 8'hFF) viol_count <= viol_count + 8'h1;
            // Write-1-to-set: zeros never clear a lock bit.
            if (is_write && is_lock) lock_status <= lock_status | write_data[REGIONS-1:0];
        end
    end

endmodule

// File: tb/tb_reglk_mem_ctrl.sv
// Self-checking bench for reglk_mem_ctrl: directed steps plus a short random
// sub-word section checked against a local word model.
module tb_reglk_mem_ctrl;

    localparam logic [31:0] LOCK_ADDR = 32'h0000_0FF0;
    localparam logic [31:0] KEY_ADDR  = 32'h0000_0FF4;
    localparam logic [31:0] KEY0      = 32'hA5A5_0001;
    localparam logic [31:0] KEY1      = 32'h5A5A_0002;

    localparam logic [2:0] SB = 3'b000, SH = 3'b001, WW = 3'b010,
                           UB = 3'b100, UH = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        write_enable = 1'b0;
    logic [2:0]  mem_width = 3'b010;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        rvalid;
    logic [7:0]  lock_status;
    logic        unlocked;
    logic        violation;
    logic [7:0]  viol_count;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int exp_vc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mdl [32];

    reglk_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .write_enable(write_enable),
        .mem_width(mem_width), .addr(addr), .write_data(write_data),
        .read_data(read_data), .rvalid(rvalid), .lock_status(lock_status),
        .unlocked(unlocked), .violation(violation), .viol_count(viol_count),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each read pushes its expected data; rvalid pops it.
    always @(negedge clk) begin
        if (!rst && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid), 32'h0);
            end else begin
                chk("read_data", read_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Each access consumes exactly one posedge and returns at edge+1.
    task automatic access(input logic we, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        req = 1'b1; write_enable = we; mem_width = w; addr = a; write_data = d;
        @(posedge clk);
        #1;
        req = 1'b0; write_enable = 1'b0;
    endtask

    task automatic wr(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        access(1'b1, w, a, d);
    endtask

    task automatic rd(input logic [2:0] w, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        access(1'b0, w, a, 32'h0);
        chk("rvalid", 32'(rvalid), 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_viol(input string tag, input logic exp_pulse);
        if (exp_pulse) exp_vc++;
        chk({tag, "_violation"}, 32'(violation), 32'(exp_pulse));
        chk({tag, "_viol_count"}, 32'(viol_count), (exp_vc > 255) ? 32'd255 : 32'(exp_vc));
    endtask

    function automatic logic [31:0] extract(input logic [31:0] wd, input logic [2:0] w,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = wd[off*8 +: 8];
        h = off[1] ? wd[31:16] : wd[15:0];
        case (w)
            SB:      return {{24{b[7]}}, b};
            UB:      return {24'h0, b};
            SH:      return {{16{h[15]}}, h};
            UH:      return {16'h0, h};
            default: return wd;
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0] widths [6];
        widths = '{SB, SH, WW, UB, UH, 3'b111};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_lock_status", 32'(lock_status), 32'h0);
        chk("rst_unlocked", 32'(unlocked), 32'h0);
        chk("rst_violation", 32'(violation), 32'h0);
        chk("rst_viol_count", 32'(viol_count), 32'h0);
        rst = 1'b0;
        idle(1);
        chk("idle_state", 32'(dbg_state), 32'h0);

        // Basic word write and sub-word reads.
        wr(WW, 32'h84, 32'hDEADBEEF);
        chk_viol("wr84", 1'b0);
        rd(SB, 32'h85, 32'hFFFFFFBE);
        rd(UH, 32'h86, 32'h0000DEAD);
        rd(SH, 32'h86, 32'hFFFFDEAD);
        rd(UB, 32'h87, 32'h000000DE);
        rd(WW, 32'h84, 32'hDEADBEEF);

        // Lock region 1; the very next write to it is blocked.
        wr(SB, LOCK_ADDR, 32'h2);
        chk("lock_set", 32'(lock_status), 32'h2);
        wr(SB, 32'h84, 32'h11);
        chk_viol("locked_wr", 1'b1);
        rd(WW, 32'h84, 32'hDEADBEEF);
        chk_viol("pulse_end", 1'b0);
        wr(WW, LOCK_ADDR, 32'h0);
        chk("lock_sticky", 32'(lock_status), 32'h2);
        rd(WW, LOCK_ADDR, 32'h2);

        // Debug unlock window.
        wr(WW, KEY_ADDR, KEY0);
        chk("armed", 32'(dbg_state), 32'h1);
        wr(WW, KEY_ADDR, KEY1);
        chk("open_state", 32'(dbg_state), 32'h2);
        chk("open_unlocked", 32'(unlocked), 32'h1);
        wr(SB, 32'h84, 32'h11);
        chk_viol("unlocked_wr", 1'b0);
        rd(WW, 32'h84, 32'hDEADBE11);
        rd(WW, KEY_ADDR, 32'h1);
        idle(1020);
        chk("window_last", 32'(unlocked), 32'h1);
        chk("window_lock", 32'(lock_status), 32'h2);
        idle(1);
        chk("window_closed", 32'(unlocked), 32'h0);
        chk("window_idle", 32'(dbg_state), 32'h0);
        wr(WW, 32'h84, 32'h12345678);
        chk_viol("relocked_wr", 1'b1);
        rd(WW, 32'h84, 32'hDEADBE11);
        chk("lock_after", 32'(lock_status), 32'h2);

        // A non-key request while ARMED abandons the sequence.
        wr(WW, KEY_ADDR, KEY0);
        rd(WW, 32'h84, 32'hDEADBE11);
        chk("armed_abort", 32'(dbg_state), 32'h0);
        wr(WW, KEY_ADDR, KEY1);
        chk_viol("stray_key1", 1'b0);
        chk("stray_key1_unl", 32'(unlocked), 32'h0);
        wr(WW, KEY_ADDR, 32'h0);
        chk_viol("bad_key", 1'b1);

        // Idle cycles hold ARMED; a wrong second key disarms with violation.
        wr(WW, KEY_ADDR, KEY0);
        idle(3);
        chk("armed_hold", 32'(dbg_state), 32'h1);
        wr(WW, KEY_ADDR, KEY0);
        chk_viol("wrong_key1", 1'b1);
        chk("wrong_key1_st", 32'(dbg_state), 32'h0);

        // Out of range.
        wr(WW, 32'h400, 32'hCAFEF00D);
        chk_viol("oor_wr", 1'b1);
        rd(WW, 32'h400, 32'h0);
        chk_viol("oor_rd", 1'b1);

        // Random sub-word traffic in unlocked region 0 against a word model.
        for (int i = 0; i < 32; i++) begin
            mdl[i] = $urandom;
            wr(WW, 32'(i * 4), mdl[i]);
        end
        for (int i = 0; i < 24; i++) begin
            int          idx;
            logic [1:0]  off;
            logic [2:0]  w;
            logic [31:0] d;
            idx = $urandom_range(0, 31);
            off = 2'($urandom_range(0, 3));
            w   = widths[$urandom_range(0, 5)];
            d   = $urandom;
            wr(w, 32'(idx * 4) | 32'(off), d);
            case (w)
                SB, UB:  mdl[idx][off*8 +: 8] = d[7:0];
                SH, UH:  if (off[1]) mdl[idx][31:16] = d[15:0]; else mdl[idx][15:0] = d[15:0];
                default: mdl[idx] = d;
            endcase
            off = 2'($urandom_range(0, 3));
            w   = widths[$urandom_range(0, 5)];
            rd(w, 32'(idx * 4) | 32'(off), extract(mdl[idx], w, off));
        end
        chk_viol("rand_clean", 1'b0);

        // Saturation of the violation counter.
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(32'h0);
            access(1'b0, WW, 32'h800, 32'h0);
            exp_vc++;
        end
        chk("viol_sat", 32'(viol_count), 32'd255);

        // Asynchronous reset while OPEN with every region locked.
        wr(WW, LOCK_ADDR, 32'hFF);
        wr(WW, KEY_ADDR, KEY0);
        wr(WW, KEY_ADDR, KEY1);
        idle(5);
        chk("pre_rst_unl", 32'(unlocked), 32'h1);
        chk("pre_rst_lock", 32'(lock_status), 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lock", 32'(lock_status), 32'h0);
        chk("arst_unlocked", 32'(unlocked), 32'h0);
        chk("arst_viol_count", 32'(viol_count), 32'h0);
        chk("arst_state", 32'(dbg_state), 32'h0);
        chk("arst_rvalid", 32'(rvalid), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
